fp_mul_ext: RTL
===============

FP_MUL_EXT -- requirements
Module: fp_mul_ext

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, stored fraction width; DATA_W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clk  in  1  clock.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports in_valid in 1 and in_ready out 1: operand handshake.
REQ-006 SHALL have ports op_a and op_b, in, DATA_W each: IEEE-style operands {sign, exp, frac}.
REQ-007 SHALL have ports out_valid out 1 and out_ready in 1: result handshake.
REQ-008 SHALL have port res out DATA_W: product.
REQ-009 SHALL have ports overflow, underflow, invalid and inexact, out, 1 each: flags qualified by out_valid.

Function
REQ-010 SHALL compute res = op_a*op_b with round-to-nearest-even; BIAS = 2^(EXP_W-1)-1.
REQ-011 SHALL have fixed latency 4: an operand accepted at edge N appears with out_valid=1 after edge N+4, absent stall.
REQ-012 SHALL transfer on in_valid&in_ready and on out_valid&out_ready.
REQ-013 SHALL hold all stages when out_valid=1 and out_ready=0; in_ready = !(out_valid & !out_ready), combinational.
REQ-014 SHALL accept one operation per cycle with no bubbles while out_ready=1.
REQ-015 SHALL deliver results in acceptance order, with none lost or duplicated under any stall pattern.
REQ-016 Stage 1 SHALL register operands, classify them (zero, inf, NaN, normal), flush subnormal inputs to signed zero, and compute sign = sa^sb.
REQ-017 Stage 2 SHALL form the (2*MAN_W+2)-bit significand product and the exponent ea+eb-BIAS in EXP_W+2-bit signed arithmetic.
REQ-018 Stage 3 SHALL normalise: if product MSB=1, shift right 1 and exponent+1; keep MAN_W+1 bits plus guard, round and sticky (OR of all lower bits).
REQ-019 Stage 4 SHALL round RNE: increment when G&(R|S|LSB); on mantissa carry-out, increment exponent and renormalise.
REQ-020 SHALL set inexact when G|R|S after normalisation.
REQ-021 Overflow: if the final exponent >= 2^EXP_W-1, SHALL output signed inf and set overflow=1 and inexact=1.
REQ-022 Underflow: if the final exponent <= 0, SHALL output signed zero (FTZ) and set underflow=1 and inexact=1.
REQ-023 SHALL output canonical qNaN {0, all-ones exp, 1 followed by zeros} for any NaN input or for zero*inf; invalid=1 only for zero*inf or a signalling NaN input.
REQ-024 For inf*nonzero SHALL output signed inf; for zero*finite SHALL output signed zero; no flags set.
REQ-025 Special-case results SHALL bypass the rounding path and report the same 4-cycle latency.
REQ-026 res and flags SHALL stay stable while out_valid=1 and out_ready=0.

Reset
REQ-027 During rst, SHALL clear all stage valid bits, out_valid, res and all flags to 0.
REQ-028 Reset mid-operation SHALL discard in-flight operations; no out_valid in the cycle after rst deasserts.
REQ-029 in_ready SHALL be 1 in the first cycle after reset.

Structure
REQ-030 Shared package fp_pkg SHALL hold BIAS/QNAN/INF derivation functions, the operand-class encoding and the flag bit ordering.
REQ-031 Rounding SHALL be one sub-module, fp_round_rne (parameters EXP_W, MAN_W; combinational; mantissa+GRS in, rounded mantissa, exponent and carry out), instantiated in stage 4.
REQ-032 Multiplier inference SHALL be left to synthesis; no vendor primitives.

Verification (defaults EXP_W=8, MAN_W=23)
REQ-033 0x40000000 * 0x40400000 -> res 0x40C00000, no flags, out_valid exactly 4 cycles after acceptance.
REQ-034 0x3FC00000 * 0x3FC00000 -> 0x40100000; 0x3F800001 * 0x3F800001 -> 0x3F800002 with inexact=1.
REQ-035 0x7F000000 * 0x40000000 -> 0x7F800000 with overflow=1; 0x80800000 * 0x3F000000 -> 0x80000000 with underflow=1.
REQ-036 0x00000000 * 0x7F800000 -> 0x7FC00000 with invalid=1; 0x7FC00000 * 0x3F800000 -> 0x7FC00000 with invalid=0.
REQ-037 8 back-to-back operations with out_ready low for 3 cycles mid-stream -> all 8 results in order, stable while stalled, in_ready low during the stall.
REQ-038 rst asserted 2 cycles after 3 acceptances -> no out_valid afterwards until new input; flags and res read 0.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared floating-point helpers: operand classes, flag bit ordering and
// width-generic derivations of the bias, infinity and quiet-NaN patterns.
package fp_pkg;

    // Operand classification after subnormal flush.
    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_NORM = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } fp_class_e;

    // Bit positions inside the internal flag vector.
    localparam int FLAG_INEXACT   = 0;
    localparam int FLAG_INVALID   = 1;
    localparam int FLAG_UNDERFLOW = 2;
    localparam int FLAG_OVERFLOW  = 3;
    localparam int FLAG_W         = 4;

    // Exponent bias for a given exponent width.
    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Signed infinity, right-aligned in 64 bits; callers truncate to DATA_W.
    function automatic logic [63:0] fp_inf(input logic sign, input int exp_w, input int man_w);
        logic [63:0] v;
        v = ((64'd1 << exp_w) - 64'd1) << man_w;
        v = v | ({63'd0, sign} << (exp_w + man_w));
        return v;
    endfunction

    // Canonical quiet NaN: positive, all-ones exponent, fraction MSB set.
    function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
        return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
    endfunction

    // Classify from exponent/fraction summaries; subnormals count as zero.
    function automatic fp_class_e fp_classify(input logic exp_ones, input logic exp_zero,
                                              input logic frac_zero);
        if (exp_ones) return frac_zero ? CLS_INF : CLS_NAN;
        if (exp_zero) return CLS_ZERO;
        return CLS_NORM;
    endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Combinational round-to-nearest-even of a normalised mantissa with
// guard/round/sticky bits; renormalises when rounding carries out.
module fp_round_rne #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [MAN_W:0]         mant_in,
    input  logic                   guard,
    input  logic                   round,
    input  logic                   sticky,
    input  logic signed [EXP_W+1:0] exp_in,
    output logic [MAN_W:0]         mant_out,
    output logic signed [EXP_W+1:0] exp_out,
    output logic                   carry
);

    localparam logic signed [EXP_W+1:0] ONE_X = (EXP_W + 2)'(1);

    logic             inc;
    logic [MAN_W+1:0] sum;

    // Increment on a tie only when the kept LSB is odd; a carry-out means the
    // mantissa became 10.000..., so shift it back and bump the exponent.
    always_comb begin
        inc   = guard & (round | sticky | mant_in[0]);
        sum   = {1'b0, mant_in} + {{(MAN_W + 1){1'b0}}, inc};
        carry = sum[MAN_W+1];
        if (carry) begin
            mant_out = sum[MAN_W+1:1];
            exp_out  = exp_in + ONE_X;
        end else begin
            mant_out = sum[MAN_W:0];
            exp_out  = exp_in;
        end
    end

endmodule

// File: rtl/fp_mul_ext.sv
// Pipelined IEEE-style multiplier with RNE rounding, flush-to-zero and
// overflow/underflow/invalid/inexact flags. Four stages feed an output
// register, so a result appears four edges after its operands are taken.
//
// Handshake: a transfer happens on an edge where valid & ready are both 1.
// The whole pipeline advances together unless the output holds an unread
// result (out_valid & !out_ready); in_ready is exactly that advance enable,
// so operands are never taken while a stall is in effect and nothing held
// inside the pipeline is overwritten.
module fp_mul_ext
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int DATA_W = 1 + EXP_W + MAN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] res,
    output logic              overflow,
    output logic              underflow,
    output logic              invalid,
    output logic              inexact
);

    localparam int PROD_W = 2 * MAN_W + 2;
    localparam int XW     = EXP_W + 2;
    localparam logic signed [XW-1:0] BIAS_X    = XW'(fp_bias(EXP_W));
    localparam logic signed [XW-1:0] EXP_LIM_X = XW'((1 << EXP_W) - 1);
    localparam logic signed [XW-1:0] ONE_X     = XW'(1);
    localparam logic signed [XW-1:0] ZERO_X    = '0;
    localparam logic [DATA_W-1:0]    QNAN      = DATA_W'(fp_qnan(EXP_W, MAN_W));

    logic adv;
    assign adv      = !(out_valid && !out_ready);
    assign in_ready = adv;

    // ---------------- stage 1: operand capture and classification ----------
    fp_class_e        cls_a_in, cls_b_in;
    logic             snan_in;
    logic             v1, sign1, snan1;
    fp_class_e        cls_a1, cls_b1;
    logic [EXP_W-1:0] ea1, eb1;
    logic [MAN_W:0]   ma1, mb1;

    // Classify operands at the ports; a NaN with fraction MSB clear is signalling.
    always_comb begin
        cls_a_in = fp_classify(&op_a[DATA_W-2:MAN_W], ~|op_a[DATA_W-2:MAN_W], ~|op_a[MAN_W-1:0]);
        cls_b_in = fp_classify(&op_b[DATA_W-2:MAN_W], ~|op_b[DATA_W-2:MAN_W], ~|op_b[MAN_W-1:0]);
        snan_in  = (cls_a_in == CLS_NAN && !op_a[MAN_W-1]) ||
                   (cls_b_in == CLS_NAN && !op_b[MAN_W-1]);
    end

    // ---------------- stage 2: special cases, product, exponent -----------
    logic                    spec_n;
    logic [DATA_W-1:0]       spec_res_n;
    logic [FLAG_W-1:0]       spec_flags_n;
    logic [PROD_W-1:0]       prod_n;
    logic signed [XW-1:0]    exp_n;
    logic                    v2, sign2, spec2;
    logic [DATA_W-1:0]       spec_res2;
    logic [FLAG_W-1:0]       spec_flags2;
    logic [PROD_W-1:0]       prod2;
    logic signed [XW-1:0]    exp2;

    // Resolve non-arithmetic results early so they ride along the pipe unchanged.
    always_comb begin
        spec_n       = 1'b1;
        spec_res_n   = '0;
        spec_flags_n = '0;
        if (cls_a1 == CLS_NAN || cls_b1 == CLS_NAN) begin
            spec_res_n                 = QNAN;
            spec_flags_n[FLAG_INVALID] = snan1;
        end else if ((cls_a1 == CLS_ZERO && cls_b1 == CLS_INF) ||
                     (cls_a1 == CLS_INF && cls_b1 == CLS_ZERO)) begin
            spec_res_n                 = QNAN;
            spec_flags_n[FLAG_INVALID] = 1'b1;
        end else if (cls_a1 == CLS_INF || cls_b1 == CLS_INF) begin
            spec_res_n = DATA_W'(fp_inf(sign1, EXP_W, MAN_W));
        end else if (cls_a1 == CLS_ZERO || cls_b1 == CLS_ZERO) begin
            spec_res_n = {sign1, {(DATA_W - 1){1'b0}}};
        end else begin
            spec_n = 1'b0;
        end
        prod_n = PROD_W'(ma1) * PROD_W'(mb1);
        exp_n  = $signed({2'b00, ea1}) + $signed({2'b00, eb1}) - BIAS_X;
    end

    // ---------------- stage 3: normalisation -----------------------------
    logic [PROD_W-1:0]    norm_n;
    logic signed [XW-1:0] exp_norm_n;
    logic                 v3, sign3, spec3, g3, r3, s3;
    logic [DATA_W-1:0]    spec_res3;
    logic [FLAG_W-1:0]    spec_flags3;
    logic [MAN_W:0]       mant3;
    logic signed [XW-1:0] exp3;

    // The product of two 1.x significands lies in [1,4); align the leading one to the MSB.
    always_comb begin
        if (prod2[PROD_W-1]) begin
            norm_n     = prod2;
            exp_norm_n = exp2 + ONE_X;
        end else begin
            norm_n     = {prod2[PROD_W-2:0], 1'b0};
            exp_norm_n = exp2;
        end
    end

    // ---------------- stage 4: rounding ----------------------------------
    logic [MAN_W:0]       mant_r;
    logic signed [XW-1:0] exp_r;
    logic                 carry_r;
    logic                 unused_rnd;
    logic                 v4, sign4, spec4, inexact4;
    logic [DATA_W-1:0]    spec_res4;
    logic [FLAG_W-1:0]    spec_flags4;
    logic [MAN_W-1:0]     mant4;
    logic signed [XW-1:0] exp4;

    fp_round_rne #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
        .mant_in  (mant3),
        .guard    (g3),
        .round    (r3),
        .sticky   (s3),
        .exp_in   (exp3),
        .mant_out (mant_r),
        .exp_out  (exp_r),
        .carry    (carry_r)
    );

    // The hidden bit and the carry are already folded into exp_r.
    assign unused_rnd = carry_r ^ mant_r[MAN_W];

    // ---------------- output: range checks and packing -------------------
    logic [DATA_W-1:0] res_n;
    logic [FLAG_W-1:0] flags_n;
    logic [FLAG_W-1:0] flags_q;

    // Special results bypass the range checks; otherwise saturate to inf or flush to zero.
    always_comb begin
        res_n                 = {sign4, exp4[EXP_W-1:0], mant4};
        flags_n               = '0;
        flags_n[FLAG_INEXACT] = inexact4;
        if (spec4) begin
            res_n   = spec_res4;
            flags_n = spec_flags4;
        end else if (exp4 >= EXP_LIM_X) begin
            res_n                   = DATA_W'(fp_inf(sign4, EXP_W, MAN_W));
            flags_n[FLAG_OVERFLOW]  = 1'b1;
            flags_n[FLAG_INEXACT]   = 1'b1;
        end else if (exp4 <= ZERO_X) begin
            res_n                   = {sign4, {(DATA_W - 1){1'b0}}};
            flags_n[FLAG_UNDERFLOW] = 1'b1;
            flags_n[FLAG_INEXACT]   = 1'b1;
        end
    end

    // Valid chain and output register; reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            v4        <= 1'b0;
            out_valid <= 1'b0;
            res       <= '0;
            flags_q   <= '0;
        end else if (adv) begin
            v1        <= in_valid;
            v2        <= v1;
            v3        <= v2;
            v4        <= v3;
            out_valid <= v4;
            if (v4) begin
                res     <= res_n;
                flags_q <= flags_n;
            end
        end
    end

    // Datapath registers advance in lock-step with the valid chain.
    always_ff @(posedge clk) begin
        if (adv) begin
            sign1       <= op_a[DATA_W-1] ^ op_b[DATA_W-1];
            cls_a1      <= cls_a_in;
            cls_b1      <= cls_b_in;
            snan1       <= snan_in;
            ea1         <= op_a[DATA_W-2:MAN_W];
            eb1         <= op_b[DATA_W-2:MAN_W];
            ma1         <= {1'b1, op_a[MAN_W-1:0]};
            mb1         <= {1'b1, op_b[MAN_W-1:0]};

            sign2       <= sign1;
            spec2       <= spec_n;
            spec_res2   <= spec_res_n;
            spec_flags2 <= spec_flags_n;
            prod2       <= prod_n;
            exp2        <= exp_n;

            sign3       <= sign2;
            spec3       <= spec2;
            spec_res3   <= spec_res2;
            spec_flags3 <= spec_flags2;
            mant3       <= norm_n[PROD_W-1 -: MAN_W+1];
            g3          <= norm_n[MAN_W];
            r3          <= norm_n[MAN_W-1];
            s3          <= |norm_n[MAN_W-2:0];
            exp3        <= exp_norm_n;

            sign4       <= sign3;
            spec4       <= spec3;
            spec_res4   <= spec_res3;
            spec_flags4 <= spec_flags3;
            mant4       <= mant_r[MAN_W-1:0];
            exp4        <= exp_r;
            inexact4    <= g3 | r3 | s3;
        end
    end

    assign overflow  = flags_q[FLAG_OVERFLOW];
    assign underflow = flags_q[FLAG_UNDERFLOW];
    assign invalid   = flags_q[FLAG_INVALID];
    assign inexact   = flags_q[FLAG_INEXACT];

endmodule
